// File: rtl/wb_queue_pkg.sv
// ============================================================================
//  wb_queue_pkg -- shared types for the register write-back queue
//  Rev 1.0
// ============================================================================
`include "define.v"
`default_nettype none

package wb_queue_pkg;

   localparam int c_dw = `DSIZE;
   localparam int c_rw = `RSIZE;

   typedef struct packed {
      logic [c_rw-1:0] addr;
      logic [c_dw-1:0] data;
   } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/define.v
// ============================================================================
//  define.v -- shared datapath and register-address widths
//  Rev 1.0
// ============================================================================
`default_nettype none
`ifndef DSIZE
`define DSIZE 16
`endif
`ifndef RSIZE
`define RSIZE 4
`endif
`default_nettype wire

// File: rtl/wb_fifo.sv
// ============================================================================
//  wb_fifo -- circular entry store with two ordered push ports and one pop
//  Rev 1.0
// ============================================================================
`default_nettype none

module wb_fifo
   import wb_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  push_a_i,
   input  wb_entry_t             entry_a_i,
   input  logic                  push_b_i,
   input  wb_entry_t             entry_b_i,
   input  logic                  pop_i,
   output logic [CW-1:0]         count_o,
   output logic [PW-1:0]         rd_ptr_o,
   output wb_entry_t [DEPTH-1:0] mem_o
);

   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         wr_b_ptr;
   logic [CW-1:0]         count_q, count_d;
   wb_entry_t [DEPTH-1:0] mem_q;

   // DEPTH is a power of two, so pointer overflow is the wrap to slot 0.
   always_comb begin
      rd_ptr_d = rd_ptr_q + PW'(pop_i);
      wr_ptr_d = wr_ptr_q + PW'(push_a_i) + PW'(push_b_i);
      wr_b_ptr = wr_ptr_q + PW'(push_a_i);
      count_d  = count_q + CW'(push_a_i) + CW'(push_b_i) - CW'(pop_i);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Port b lands one slot after port a when both push together.
   always_ff @(posedge clk_i) begin
      if (push_a_i) begin
         mem_q[wr_ptr_q] <= entry_a_i;
      end
      if (push_b_i) begin
         mem_q[wr_b_ptr] <= entry_b_i;
      end
   end

   assign count_o  = count_q;
   assign rd_ptr_o = rd_ptr_q;
   assign mem_o    = mem_q;

endmodule

`default_nettype wire

// File: rtl/wb_queue.sv
// ============================================================================
//  wb_queue -- register write-back queue merging ALU and load results,
//              with forwarding lookup of pending writes.  Rev 1.0
// ============================================================================
`default_nettype none

module wb_queue
   import wb_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic            Clock,
   input  logic            Reset,
   input  logic            AluValid,
   input  logic [c_rw-1:0] AluAddr,
   input  logic [c_dw-1:0] AluData,
   input  logic            MemValid,
   input  logic [c_rw-1:0] MemAddr,
   input  logic [c_dw-1:0] MemData,
   output logic            InReady,
   input  logic            Stall,
   output logic            Wen,
   output logic [c_rw-1:0] WAddr,
   output logic [c_dw-1:0] WData,
   input  logic [c_rw-1:0] QAddr1,
   input  logic [c_rw-1:0] QAddr2,
   output logic            Hit1,
   output logic            Hit2,
   output logic [c_dw-1:0] FData1,
   output logic [c_dw-1:0] FData2,
   output logic            Empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic                  alu_push;
   logic                  mem_push;
   logic                  pop;
   wb_entry_t             alu_entry;
   wb_entry_t             mem_entry;
   wb_entry_t             head;
   logic [CW-1:0]         count;
   logic [PW-1:0]         rd_ptr;
   wb_entry_t [DEPTH-1:0] ents;

   // Two free slots guarantee room for a dual push.
   assign InReady   = (count <= CW'(DEPTH - 2));
   assign Empty     = (count == '0);
   assign alu_push  = AluValid && InReady && (AluAddr != '0);
   assign mem_push  = MemValid && InReady && (MemAddr != '0);
   assign alu_entry = '{addr: AluAddr, data: AluData};
   assign mem_entry = '{addr: MemAddr, data: MemData};

   // Pending entries are dropped, never written, when reset hits.
   assign pop   = !Empty && !Stall && !Reset;
   assign head  = ents[rd_ptr];
   assign Wen   = pop;
   assign WAddr = pop ? head.addr : '0;
   assign WData = pop ? head.data : '0;

   wb_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk_i     (Clock),
      .rst_i     (Reset),
      .push_a_i  (alu_push),
      .entry_a_i (alu_entry),
      .push_b_i  (mem_push),
      .entry_b_i (mem_entry),
      .pop_i     (pop),
      .count_o   (count),
      .rd_ptr_o  (rd_ptr),
      .mem_o     (ents)
   );

   // Scans oldest to youngest so the last match is the youngest.
   function automatic logic [c_dw:0] fwd_lookup(
      input logic [c_rw-1:0]        qa,
      input logic [CW-1:0]          cnt,
      input logic [PW-1:0]          rp,
      input wb_entry_t [DEPTH-1:0]  e
   );
      logic [c_dw:0] r;
      logic [PW-1:0] idx;
      r = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rp + PW'(i);
         if ((qa != '0) && (CW'(i) < cnt) && (e[idx].addr == qa)) begin
            r = {1'b1, e[idx].data};
         end
      end
      return r;
   endfunction

   assign {Hit1, FData1} = fwd_lookup(QAddr1, count, rd_ptr, ents);
   assign {Hit2, FData2} = fwd_lookup(QAddr2, count, rd_ptr, ents);

endmodule

`default_nettype wire

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries (power of two, at least 2).
REQ-002 Clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 AluValid  input  1  ALU result present this cycle.
REQ-005 AluAddr  input  `RSIZE  ALU destination register.
REQ-006 AluData  input  `DSIZE  ALU result.
REQ-007 MemValid  input  1  load result present this cycle.
REQ-008 MemAddr  input  `RSIZE  load destination register.
REQ-009 MemData  input  `DSIZE  load result.
REQ-010 InReady  output  1  both producer ports may present this cycle.
REQ-011 Stall  input  1  register-file write port unavailable this cycle.
REQ-012 Wen  output  1  register-file write enable.
REQ-013 WAddr  output  `RSIZE  register-file write address.
REQ-014 WData  output  `DSIZE  register-file write data.
REQ-015 QAddr1, QAddr2  input  `RSIZE each  forwarding lookup addresses.
REQ-016 Hit1, Hit2  output  1 each  a pending write to QAddrN exists.
REQ-017 FData1, FData2  output  `DSIZE each  youngest pending data for QAddrN.
REQ-018 Empty  output  1  no entries held.

Function
REQ-019 The block SHALL hold pending register writes in a circular FIFO of DEPTH entries, each entry holding {addr, data}.
REQ-020 InReady SHALL equal (count <= DEPTH-2), computed from registered count only, with no combinational path from the valid inputs.
REQ-021 A producer valid with InReady=0 SHALL be ignored; producers hold their values until InReady=1.
REQ-022 A producer valid with address 0 SHALL be dropped and not enqueued.
REQ-023 When both ports enqueue in one cycle, the ALU entry SHALL occupy the older slot and the Mem entry the next.
REQ-024 Wen SHALL be 1 exactly when count>0 and Stall=0, with WAddr/WData taken from the head entry; that entry SHALL pop at the same edge.
REQ-025 When Wen=0, WAddr and WData SHALL be driven to 0.
REQ-026 Latency: an entry accepted at edge N into an empty queue SHALL appear on Wen/WAddr/WData in the cycle after edge N.
REQ-027 Simultaneous push(es) and pop SHALL update count by (pushes - 1); count SHALL never exceed DEPTH or go below 0.
REQ-028 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-029 HitN SHALL be 1 when QAddrN != 0 and any held entry, including the head being written this cycle, matches QAddrN.
REQ-030 FDataN SHALL be the data of the youngest matching entry, and 0 when HitN=0.
REQ-031 Hit/FData SHALL be combinational from stored state and QAddrN, and SHALL exclude same-cycle inputs.
REQ-032 Empty SHALL equal (count==0).

Reset
REQ-033 While Reset=1 at an edge, count and both pointers SHALL become 0 and entry contents SHALL be don't-care.
REQ-034 In the cycle after reset: Wen=0, WAddr=0, WData=0, Empty=1, InReady=1, Hit1=Hit2=0, FData1=FData2=0.
REQ-035 Reset asserted with pending entries SHALL discard them without issuing Wen; producer valids at that edge SHALL be ignored.

Structure
REQ-036 `DSIZE (16) and `RSIZE (4) SHALL come from the shared define.v; the block SHALL NOT redefine them.
REQ-037 The FIFO storage and pointer logic MAY be a sub-module named wb_fifo; the forwarding search SHALL stay in wb_queue.

Verification
REQ-038 Reset, then AluValid with Addr=3, Data=0x1234 -> next cycle Wen=1, WAddr=3, WData=0x1234; following cycle Empty=1.
REQ-039 Same cycle Alu(5,0xAAAA) and Mem(6,0xBBBB) -> Wen on consecutive cycles, first (5,0xAAAA) then (6,0xBBBB).
REQ-040 Stall=1 held while four pushes arrive -> InReady drops to 0 at count=3; on Stall release, four writes drain in order with no loss and no duplication.
REQ-041 Enqueue (7,0x1111) then (7,0x2222) under Stall, QAddr1=7 -> Hit1=1, FData1=0x2222; QAddr2=0 -> Hit2=0.
REQ-042 AluValid with Addr=0 -> nothing enqueued; Empty stays 1 and Wen stays 0.
REQ-043 Three entries pending, then Reset=1 for one cycle -> no Wen is issued, Empty=1, and all outputs are zero.
